ov7670_config_sequencer: RTL and testbench



---
 rtl/ov7670_cfg_pkg.sv | 25 ++
 rtl/cfg_delay_timer.sv | 37 +++
 rtl/ov7670_config_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_ov7670_config_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_cfg_pkg.sv
// Shared definitions for the OV7670 configuration sequencer: ROM control words,
// the sequencer state encoding and the delay-length helper.
package ov7670_cfg_pkg;

    localparam logic [15:0] CFG_END   = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY = 16'hFFF0;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        WAIT_ROM,
        DECODE,
        REQ,
        WAIT_DONE,
        DELAY,
        ADVANCE,
        FINISH
    } cfg_state_t;

    function automatic int unsigned delay_cycles(input int unsigned clk_freq,
                                                 input int unsigned delay_ms);
        return clk_freq / 1000 * delay_ms;
    endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Loadable down-counter for the FFF0 settle delay. load presets CYCLES-1, en counts
// down one per cycle, and zero flags the final cycle of the dwell.
module cfg_delay_timer #(
    parameter int unsigned CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 init ROM from address 0 and issues each register write to the SCCB
// master. Define OV7670_CFG_NACK_RETRY_EN to retry NACKed writes up to MAX_RETRY times.
module ov7670_config_sequencer
    import ov7670_cfg_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 25_000_000,
    parameter int unsigned DELAY_MS  = 10,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_dout,
    output logic        sccb_valid,
    input  logic        sccb_ready,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_data,
    input  logic        sccb_done,
    input  logic        sccb_nack,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned DELAY_CYCLES = delay_cycles(CLK_FREQ, DELAY_MS);

    cfg_state_t  state_q, state_d;
    logic [7:0]  rom_addr_q, rom_addr_d;
    logic        sccb_valid_q, sccb_valid_d;
    logic [7:0]  sccb_reg_q, sccb_reg_d;
    logic [7:0]  sccb_data_q, sccb_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        timer_load, timer_en, timer_zero;

`ifdef OV7670_CFG_NACK_RETRY_EN
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] MAX_RETRY_W = RW'(MAX_RETRY);
    logic [RW-1:0] retry_q, retry_d;
    logic          error_q, error_d;
`else
    localparam int unsigned unused_max_retry = MAX_RETRY;
    logic unused_nack;
    assign unused_nack = sccb_nack;
`endif

    assign timer_en = (state_q == DELAY);

    cfg_delay_timer #(
        .CYCLES (DELAY_CYCLES)
    ) u_delay_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .en   (timer_en),
        .zero (timer_zero)
    );

    // Handshake: a request is offered by holding sccb_valid with stable reg/data;
    // it transfers on the rising edge where sccb_valid and sccb_ready are both 1.
    // Completion is the one-cycle sccb_done pulse, honoured only in WAIT_DONE.
    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        sccb_valid_d = sccb_valid_q;
        sccb_reg_d   = sccb_reg_q;
        sccb_data_d  = sccb_data_q;
        busy_d       = busy_q;
        done_d       = done_q;
        timer_load   = 1'b0;
`ifdef OV7670_CFG_NACK_RETRY_EN
        retry_d      = retry_q;
        error_d      = error_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    rom_addr_d = 8'd0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
`ifdef OV7670_CFG_NACK_RETRY_EN
                    retry_d    = '0;
                    error_d    = 1'b0;
`endif
                end
            end
            FETCH:    state_d = WAIT_ROM;
            WAIT_ROM: state_d = DECODE;
            DECODE: begin
                if (rom_dout == CFG_END) begin
                    state_d = FINISH;
                end else if (rom_dout == CFG_DELAY) begin
                    timer_load = 1'b1;
                    state_d    = DELAY;
                end else begin
                    sccb_reg_d   = rom_dout[15:8];
                    sccb_data_d  = rom_dout[7:0];
                    sccb_valid_d = 1'b1;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (sccb_ready) begin
                    sccb_valid_d = 1'b0;
                    state_d      = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (sccb_done) begin
`ifdef OV7670_CFG_NACK_RETRY_EN
                    if (!sccb_nack) begin
                        state_d = ADVANCE;
                    end else if (retry_q < MAX_RETRY_W) begin
                        retry_d      = retry_q + 1'b1;
                        sccb_valid_d = 1'b1;
                        state_d      = REQ;
                    end else begin
                        error_d = 1'b1;
                        state_d = FINISH;
                    end
`else
                    state_d = ADVANCE;
`endif
                end
            end
            DELAY: begin
                if (timer_zero) begin
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
`ifdef OV7670_CFG_NACK_RETRY_EN
                retry_d = '0;
`endif
                // Address 255 is the last word; the sequence never wraps to 0.
                if (rom_addr_q == 8'hFF) begin
                    state_d = FINISH;
                end else begin
                    rom_addr_d = rom_addr_q + 8'd1;
                    state_d    = FETCH;
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rom_addr_q   <= 8'd0;
            sccb_valid_q <= 1'b0;
            sccb_reg_q   <= 8'd0;
            sccb_data_q  <= 8'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef OV7670_CFG_NACK_RETRY_EN
            retry_q      <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            sccb_valid_q <= sccb_valid_d;
            sccb_reg_q   <= sccb_reg_d;
            sccb_data_q  <= sccb_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef OV7670_CFG_NACK_RETRY_EN
            retry_q      <= retry_d;
            error_q      <= error_d;
`endif
        end
    end

    assign rom_addr   = rom_addr_q;
    assign sccb_valid = sccb_valid_q;
    assign sccb_reg   = sccb_reg_q;
    assign sccb_data  = sccb_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef OV7670_CFG_NACK_RETRY_EN
    assign error      = error_q;
`else
    assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Self-checking bench for ov7670_config_sequencer: registered ROM model, SCCB
// responder that logs every accepted write, table-driven ROM programs plus corner cases.
module tb_ov7670_config_sequencer;

    localparam int unsigned CLK_FREQ     = 1_000_000;
    localparam int unsigned DELAY_MS     = 1;
    localparam int unsigned DELAY_CYCLES = 1000;
    localparam int unsigned MAX_RETRY    = 3;
    localparam int          DONE_LAT     = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dout;
    logic        sccb_valid;
    logic        sccb_ready;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_data;
    logic        sccb_done;
    logic        sccb_nack;
    logic        busy;
    logic        done;
    logic        error;

    logic [15:0] rom_mem [256];
    logic [15:0] wr_q[$];
    logic [15:0] exp_q[$];
    logic        nack_mode;
    int          checks   = 0;
    int          failures = 0;

    typedef struct {
        logic [15:0] w0, w1, w2, w3;
        int          n_wr;
        logic [15:0] e0, e1, e2;
        logic [7:0]  end_addr;
    } vec_t;
    vec_t vecs [5];

    ov7670_config_sequencer #(
        .CLK_FREQ  (CLK_FREQ),
        .DELAY_MS  (DELAY_MS),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .sccb_valid (sccb_valid),
        .sccb_ready (sccb_ready),
        .sccb_reg   (sccb_reg),
        .sccb_data  (sccb_data),
        .sccb_done  (sccb_done),
        .sccb_nack  (sccb_nack),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Clock and registered ROM model
    always #5 clk = ~clk;
    always @(posedge clk) rom_dout <= rom_mem[rom_addr];

    // SCCB responder: logs a write when valid&ready will transfer on the next edge,
    // then pulses done DONE_LAT edges later.
    initial begin
        sccb_done = 1'b0;
        sccb_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (sccb_valid && sccb_ready && !rst) begin
                wr_q.push_back({sccb_reg, sccb_data});
                repeat (DONE_LAT) @(posedge clk);
                #1;
                sccb_done = 1'b1;
                sccb_nack = nack_mode;
                @(posedge clk);
                #1;
                sccb_done = 1'b0;
                sccb_nack = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_rom(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
        rom_mem[0] = w0;
        rom_mem[1] = w1;
        rom_mem[2] = w2;
        rom_mem[3] = w3;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_finish(input string name, input int budget);
        int cyc;
        cyc = 0;
        while (!(done && !busy) && cyc < budget) begin
            tick(1);
            cyc++;
        end
        check(name, {31'd0, done && !busy}, 32'd1);
    endtask

    initial begin
        int   cyc;
        logic stable;
        logic same;
        logic seen_nz;
        logic wrapped;

        rst        = 1'b1;
        start      = 1'b0;
        sccb_ready = 1'b1;
        nack_mode  = 1'b0;
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;

        vecs[0] = '{16'h1280, 16'hFFF0, 16'h1210, 16'hFFFF, 2, 16'h1280, 16'h1210, 16'h0000, 8'd3};
        vecs[1] = '{16'hFFFF, 16'h1234, 16'hFFFF, 16'hFFFF, 0, 16'h0000, 16'h0000, 16'h0000, 8'd0};
        vecs[2] = '{16'h0102, 16'h0304, 16'h0506, 16'hFFFF, 3, 16'h0102, 16'h0304, 16'h0506, 8'd3};
        vecs[3] = '{16'hFFF0, 16'hFFF0, 16'hFFFF, 16'h1111, 0, 16'h0000, 16'h0000, 16'h0000, 8'd2};
        vecs[4] = '{16'hABCD, 16'hFFFF, 16'h5555, 16'hFFFF, 1, 16'hABCD, 16'h0000, 16'h0000, 8'd1};

        // Reset state
        tick(4);
        check("rst rom_addr", rom_addr, 0);
        check("rst sccb_valid", sccb_valid, 0);
        check("rst sccb_reg", sccb_reg, 0);
        check("rst sccb_data", sccb_data, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst error", error, 0);
        rst = 1'b0;
        tick(2);
        check("idle busy", busy, 0);

        // Table of ROM programs
        for (int i = 0; i < 5; i++) begin
            load_rom(vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].w3);
            wr_q.delete();
            exp_q.delete();
            if (vecs[i].n_wr > 0) exp_q.push_back(vecs[i].e0);
            if (vecs[i].n_wr > 1) exp_q.push_back(vecs[i].e1);
            if (vecs[i].n_wr > 2) exp_q.push_back(vecs[i].e2);
            pulse_start();
            wait_finish($sformatf("vec%0d finish", i), 5000);
            check($sformatf("vec%0d count", i), wr_q.size(), vecs[i].n_wr);
            for (int k = 0; k < vecs[i].n_wr && wr_q.size() > 0 && exp_q.size() > 0; k++) begin
                check($sformatf("vec%0d write%0d", i, k), wr_q.pop_front(), exp_q.pop_front());
            end
            check($sformatf("vec%0d end addr", i), rom_addr, vecs[i].end_addr);
            check($sformatf("vec%0d error", i), error, 0);
        end

        // Delay dwell: done edge -> ADVANCE, FETCH, WAIT_ROM, DECODE, DELAY_CYCLES in
        // DELAY, ADVANCE; address 2 appears DELAY_CYCLES+5 edges after the done edge.
        load_rom(16'h1280, 16'hFFF0, 16'h1210, 16'hFFFF);
        wr_q.delete();
        pulse_start();
        cyc = 0;
        while (!sccb_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("delay first done seen", sccb_done, 1);
        @(posedge clk);
        cyc = 0;
        do begin
            tick(1);
            cyc++;
        end while (rom_addr != 8'd2 && cyc < 3000);
        check("delay gap cycles", cyc, DELAY_CYCLES + 5);
        wait_finish("delay finish", 200);
        check("delay count", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            check("delay write0", wr_q[0], 16'h1280);
            check("delay write1", wr_q[1], 16'h1210);
        end

        // Back-pressure: ready low for 20 cycles while a request is pending
        load_rom(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        wr_q.delete();
        sccb_ready = 1'b0;
        pulse_start();
        cyc = 0;
        while (!sccb_valid && cyc < 50) begin
            tick(1);
            cyc++;
        end
        check("stall valid seen", sccb_valid, 1);
        stable = 1'b1;
        repeat (20) begin
            tick(1);
            if (!(sccb_valid === 1'b1 && sccb_reg === 8'h12 && sccb_data === 8'h80)) stable = 1'b0;
        end
        check("stall hold", stable, 1);
        check("stall no transfer", wr_q.size(), 0);
        sccb_ready = 1'b1;
        wait_finish("stall finish", 200);
        check("stall one transfer", wr_q.size(), 1);
        if (wr_q.size() > 0) check("stall word", wr_q[0], 16'h1280);

        // Reset during DELAY at address 1
        load_rom(16'h1280, 16'hFFF0, 16'h1210, 16'hFFFF);
        wr_q.delete();
        pulse_start();
        cyc = 0;
        while (rom_addr != 8'd1 && cyc < 100) begin
            tick(1);
            cyc++;
        end
        tick(20);
        check("pre-reset addr", rom_addr, 1);
        check("pre-reset busy", busy, 1);
        rst = 1'b1;
        tick(1);
        check("abort rom_addr", rom_addr, 0);
        check("abort sccb_valid", sccb_valid, 0);
        check("abort sccb_reg", sccb_reg, 0);
        check("abort sccb_data", sccb_data, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort error", error, 0);
        rst = 1'b0;
        tick(1);
        wr_q.delete();
        pulse_start();
        check("restart addr", rom_addr, 0);
        check("restart busy", busy, 1);
        wait_finish("restart finish", 3000);
        check("restart count", wr_q.size(), 2);

        // No end marker: 256 writes, no wrap
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'h0102;
        wr_q.delete();
        pulse_start();
        seen_nz = 1'b0;
        wrapped = 1'b0;
        cyc = 0;
        while (!(done && !busy) && cyc < 20000) begin
            tick(1);
            cyc++;
            if (rom_addr != 8'd0) seen_nz = 1'b1;
            else if (seen_nz && busy) wrapped = 1'b1;
        end
        check("full finish", {31'd0, done && !busy}, 32'd1);
        check("full count", wr_q.size(), 256);
        check("full no wrap", wrapped, 0);
        check("full end addr", rom_addr, 8'hFF);

        // start while busy is ignored; start after done reruns and clears done
        load_rom(16'h0102, 16'h0304, 16'h0506, 16'hFFFF);
        wr_q.delete();
        pulse_start();
        cyc = 0;
        while (!sccb_valid && cyc < 50) begin
            tick(1);
            cyc++;
        end
        pulse_start();
        check("busy start addr", rom_addr, 0);
        check("busy start busy", busy, 1);
        wait_finish("busy start finish", 500);
        check("busy start count", wr_q.size(), 3);
        check("busy start end addr", rom_addr, 3);
        wr_q.delete();
        pulse_start();
        check("rerun done cleared", done, 0);
        check("rerun busy", busy, 1);
        wait_finish("rerun finish", 500);
        check("rerun count", wr_q.size(), 3);

        // NACK on every completion
        load_rom(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        wr_q.delete();
        nack_mode = 1'b1;
        pulse_start();
        wait_finish("nack finish", 500);
        nack_mode = 1'b0;
`ifdef OV7670_CFG_NACK_RETRY_EN
        check("nack requests", wr_q.size(), MAX_RETRY + 1);
        check("nack error", error, 1);
        check("nack end addr", rom_addr, 0);
`else
        check("nack requests", wr_q.size(), 1);
        check("nack error", error, 0);
        check("nack end addr", rom_addr, 1);
`endif
        same = 1'b1;
        foreach (wr_q[i]) if (wr_q[i] !== 16'h1280) same = 1'b0;
        check("nack same word", same, 1);
        wr_q.delete();
        pulse_start();
        check("error cleared on start", error, 0);
        wait_finish("post-nack finish", 500);
        check("post-nack count", wr_q.size(), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
